// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: VGA pixel fetches pre-empt buffered UART writes to a single-port RAM.
// Define FB_ARB_BLANK_WRITE_EN to confine RAM writes to the blanking interval.
module fb_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_40,
  input  logic                          reset_n,
  input  logic                          vid_req,
  input  logic [ADDR_W-1:0]             vid_addr,
  output logic                          vid_rvalid,
  output logic [2:0]                    vid_rdata,
  input  logic                          video_blank,
  input  logic                          wr_valid,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [2:0]                    wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ram_en,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic [2:0]                    ram_wdata,
  input  logic [2:0]                    ram_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [2:0]        fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_stage2;
  logic              win;
  logic              push;
  logic              pop;

`ifdef FB_ARB_BLANK_WRITE_EN
  assign win = !vid_req && video_blank;
`else
  logic blank_unused;
  assign blank_unused = video_blank;
  assign win = !vid_req;
`endif

  assign wr_ready = (fifo_level < DEPTH_L);
  assign push     = wr_valid && wr_ready;
  assign pop      = win && (fifo_level != '0);

  always_ff @(posedge clk_40) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  // READ state doubles as the first stage of the pixel return pipeline.
  always_ff @(posedge clk_40 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= 3'b000;
      rd_stage2  <= 1'b0;
      vid_rvalid <= 1'b0;
      vid_rdata  <= 3'b000;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      if (vid_req) begin
        state    <= READ;
        ram_en   <= 1'b1;
        ram_we   <= 1'b0;
        ram_addr <= vid_addr;
      end else if (pop) begin
        state     <= WRITE;
        ram_en    <= 1'b1;
        ram_we    <= 1'b1;
        ram_addr  <= fifo_addr[rd_ptr];
        ram_wdata <= fifo_data[rd_ptr];
      end else begin
        state  <= IDLE;
        ram_en <= 1'b0;
        ram_we <= 1'b0;
      end

      rd_stage2  <= (state == READ);
      vid_rvalid <= rd_stage2;
      vid_rdata  <= rd_stage2 ? ram_rdata : 3'b000;
    end
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, frame-buffer word address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries, power of two, 2..16.
REQ-003 SHALL have port clk_40  input  1  pixel clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port vid_req  input  1  pixel fetch request from VGA timing, one per cycle.
REQ-006 SHALL have port vid_addr  input  ADDR_W  pixel fetch address.
REQ-007 SHALL have port vid_rvalid  output  1  fetched pixel valid.
REQ-008 SHALL have port vid_rdata  output  3  fetched RGB pixel.
REQ-009 SHALL have port video_blank  input  1  high outside the visible area.
REQ-010 SHALL have port wr_valid  input  1  UART-side write request.
REQ-011 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-012 SHALL have port wr_data  input  3  write RGB value.
REQ-013 SHALL have port wr_ready  output  1  write buffer can accept.
REQ-014 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  buffered write count.
REQ-015 SHALL have ports ram_en, ram_we  output  1 each, ram_addr  output  ADDR_W, ram_wdata  output  3; all registered; single-port RAM control.
REQ-016 SHALL have port ram_rdata  input  3  RAM read data, valid one cycle after ram_en with ram_we=0.

Function
REQ-017 SHALL run a 3-state FSM: IDLE, READ, WRITE; state updates every cycle, no wait states.
REQ-018 SHALL enter READ whenever vid_req=1 at an edge, regardless of previous state; video has absolute priority.
REQ-019 SHALL enter WRITE when vid_req=0, FIFO non-empty and the write window is open (REQ-030/031); otherwise IDLE.
REQ-020 READ: ram_en=1, ram_we=0, ram_addr=captured vid_addr in the cycle after the request edge.
REQ-021 WRITE: pops FIFO head at the entering edge; ram_en=1, ram_we=1, ram_addr/ram_wdata=popped entry in the following cycle.
REQ-022 IDLE: ram_en=0, ram_we=0; ram_addr/ram_wdata hold last values.
REQ-023 vid_rvalid SHALL be 1 exactly two cycles after each edge sampling vid_req=1; vid_rdata=ram_rdata in that cycle, 3'b000 when vid_rvalid=0.
REQ-024 Back-to-back vid_req SHALL give one vid_rvalid per cycle, fully pipelined, order preserved.
REQ-025 FIFO push on edge with wr_valid=1 and wr_ready=1; wr_ready=1 iff fifo_level<FIFO_DEPTH; no bypass when full.
REQ-026 Simultaneous push and pop SHALL leave fifo_level unchanged; pop from empty never occurs.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; writes reach RAM in push order.
REQ-028 A pending write interrupted by vid_req stays at FIFO head; never dropped or duplicated.

Reset
REQ-029 On reset_n=0, asynchronously: state=IDLE, FIFO empty, fifo_level=0, wr_ready=1, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, vid_rvalid=0, vid_rdata=0; in-flight reads and buffered writes discarded; release synchronous to clk_40.

Configuration
REQ-030 With FB_ARB_BLANK_WRITE_EN defined, write window open only when video_blank=1 and vid_req=0.
REQ-031 Without FB_ARB_BLANK_WRITE_EN, write window open whenever vid_req=0; video_blank ignored.

Verification
REQ-032 Reset, then vid_req=1 addr 0x0010 one cycle, RAM holding 3'b101 -> ram_en=1 addr 0x0010 next cycle; vid_rvalid=1, vid_rdata=3'b101 two cycles after request.
REQ-033 Push 4 writes (addr 1..4, data 1..4) with vid_req=0 -> wr_ready=0 after 4th push if not drained; RAM writes addr 1,2,3,4 in order, fifo_level returns to 0.
REQ-034 vid_req held 1 for 800 cycles while 2 writes pushed -> zero ram_we pulses during period; both writes issued in first 2 cycles after vid_req falls.
REQ-035 FIFO full, push and pop same edge -> push refused (wr_ready=0), fifo_level 4->3, no entry lost.
REQ-036 reset_n pulsed low mid-stream with 3 buffered writes and 2 reads in flight -> all outputs reset immediately; no vid_rvalid, no RAM write after release.
REQ-037 With FB_ARB_BLANK_WRITE_EN, video_blank=0, vid_req=0, one write buffered -> no write until video_blank=1; then write next cycle.
